serial_ram_model: RTL and testbench
===================================

Name: serial_ram_model

Overview:
- Behavioural model of a nibble-serial external RAM, used in simulation alongside the retro-console top level.
- Host drives a 4-bit address/command bus. The model returns 16-bit words as four 4-bit nibbles after a programmable latency.
- Supports single-word reads and writes to a 2^RAM_ADDR_BITS x 16-bit array.

Parameters:
- RAM_ADDR_BITS, 16: word-address width. Must be a multiple of 4. Address takes NA = RAM_ADDR_BITS/4 nibbles.
- DELAY, 9: extra read-latency cycles between the last address nibble and the first data nibble (0..255).

Ports:
- clk, input, 1: clock; all state changes on posedge.
- rst_n, input, 1: reset, synchronous, active-low.
- enable, input, 1: when 0 the FSM, counters and data_out hold; memory is not written.
- addr_in, input, 4: command/address/write-data nibble bus from host.
- data_out, output, 4: read-data nibble bus to host.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, data_out=4'h0, counters cleared. Memory contents are preserved.
- All behaviour below applies only at posedges with rst_n=1 and enable=1.
- IDLE:
  - addr_in=4'h1 → latch READ, go to ADDR.
  - addr_in=4'h3 → latch WRITE, go to ADDR.
  - Any other value → stay in IDLE. data_out=0.
- ADDR:
  - Samples NA consecutive nibbles into the address register, least-significant nibble first.
  - After the NA-th nibble: READ → WAIT; WRITE → WDATA.
- WDATA:
  - Samples 4 nibbles, LSN first, into the write word.
  - On the 4th nibble, mem[addr] is written at that same edge; then go to IDLE.
- WAIT:
  - Counts DELAY cycles, then goes to DATA.
  - If DELAY=0, goes straight from ADDR to DATA.
- DATA:
  - data_out is registered.
  - Let the last address nibble be sampled at edge k. Nibble i of mem[addr] (i=0..3, bits 4i+3:4i) is driven from edge k+1+DELAY+i.
  - At edge k+5+DELAY, data_out returns to 0 and state returns to IDLE.
- addr_in is ignored during WAIT and DATA; a start nibble there does not begin a new transaction.
- The earliest new start nibble is sampled at edge k+5+DELAY.
- The read word is captured from the array at edge k+1+DELAY, so read-after-write returns the newly written value.
- Reset mid-transaction aborts it with no memory write. A partially shifted write is discarded.
- enable=0 freezes everything, including the delay count, for any number of cycles. The transaction resumes unchanged when enable returns to 1.
- Address register width is exactly RAM_ADDR_BITS, so no wrap-around handling is needed.

Optional Feature:
- Macro SERIAL_RAM_INIT_EN.
- When defined: at time zero every word is preloaded with mem[a] = a[15:0] ^ 16'hA5A5 (a truncated or zero-extended to 16 bits).
- When undefined: memory starts as X; reads before any write return X nibbles.
- Reset never alters memory in either case.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with addr_in=1 → data_out=0, state IDLE; no transaction starts until rst_n=1.
- Write then read, DELAY=9:
  - Write: nibbles 3, 4,3,2,1, then D,C,B,A (writes word 0xABCD to address 0x1234).
  - Read: nibbles 1, 4,3,2,1 → data_out=0 for 9 cycles, then D,C,B,A on consecutive cycles, then 0.
- DELAY=0 read: last address nibble at edge k → data_out=D at edge k+1.
- enable low mid-WAIT for 5 cycles → first data nibble is delayed by exactly 5 cycles; values are unchanged.
- Start nibble 1 issued during DATA → ignored, no new read.
- Init macro on: read address 0x0000 → 5,A,5,A. Read address 0xFFFF → A,5,A,5.
- Reset pulse during WDATA of a write to 0x0010 → a later read of 0x0010 returns the old contents.

Source files
------------

// File: rtl/serial_ram_model.sv
// Nibble-serial external RAM model: 4-bit command/address/data bus, 16-bit words, programmable read latency.
// Optional SERIAL_RAM_INIT_EN preloads mem[a] = a[15:0] ^ 16'hA5A5 at time zero.
module serial_ram_model #(
  parameter int RAM_ADDR_BITS = 16,
  parameter int DELAY         = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] addr_in,
  output logic [3:0] data_out
);

  localparam int         NA        = RAM_ADDR_BITS / 4;
  localparam int         DEPTH     = 1 << RAM_ADDR_BITS;
  localparam logic [7:0] LAST_ADDR = 8'(NA - 1);
  localparam logic [7:0] WAIT_LOAD = 8'((DELAY > 0) ? (DELAY - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_DATA
  } state_t;

  state_t                   r_state;
  logic                     r_is_write;
  logic [7:0]               r_cnt;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [11:0]              r_wdata;
  logic [11:0]              r_word;

  logic [RAM_ADDR_BITS-1:0] w_addr_next;
  logic [15:0]              w_wr_word;
  logic [15:0]              w_rd_word;
  logic [15:0]              w_pat;
  logic                     w_mem_we;

  // Words are stored XOR-ed with w_pat so an all-zero power-up image reads back as the preload pattern.
`ifdef SERIAL_RAM_INIT_EN
  logic [15:0] r_mem [DEPTH] = '{default: 16'h0000};
  assign w_pat = 16'(r_addr) ^ 16'hA5A5;
`else
  logic [15:0] r_mem [DEPTH];
  assign w_pat = 16'h0000;
`endif

  assign w_addr_next = (r_addr >> 4) | (RAM_ADDR_BITS'(addr_in) << (RAM_ADDR_BITS - 4));
  assign w_wr_word   = {addr_in, r_wdata};
  assign w_rd_word   = r_mem[r_addr] ^ w_pat;
  assign w_mem_we    = rst_n && enable && (r_state == S_WDATA) && (r_cnt == 8'd3);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_wr_word ^ w_pat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_cnt      <= 8'd0;
      r_addr     <= '0;
      r_wdata    <= 12'h000;
      r_word     <= 12'h000;
      data_out   <= 4'h0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          data_out <= 4'h0;
          r_cnt    <= 8'd0;
          if (addr_in == 4'h1) begin
            r_is_write <= 1'b0;
            r_state    <= S_ADDR;
          end else if (addr_in == 4'h3) begin
            r_is_write <= 1'b1;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_addr <= w_addr_next;
          if (r_cnt == LAST_ADDR) begin
            r_cnt <= 8'd0;
            if (r_is_write) begin
              r_state <= S_WDATA;
            end else if (DELAY == 0) begin
              r_state <= S_DATA;
            end else begin
              r_cnt   <= WAIT_LOAD;
              r_state <= S_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WDATA: begin
          r_wdata <= w_wr_word[15:4];
          if (r_cnt == 8'd3) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DATA: begin
          // The word is sampled on the first data edge so a just-completed write is visible.
          case (r_cnt[1:0])
            2'd0: begin
              r_word   <= w_rd_word[15:4];
              data_out <= w_rd_word[3:0];
            end
            2'd1:    data_out <= r_word[3:0];
            2'd2:    data_out <= r_word[7:4];
            default: data_out <= r_word[11:8];
          endcase
          if (r_cnt == 8'd3) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ram_model.sv
// Scoreboard bench for serial_ram_model: one instance with DELAY=9 and one with DELAY=0.
module tb_serial_ram_model;

  localparam int AW   = 16;
  localparam int NA   = AW / 4;
  localparam int DLY9 = 9;

  typedef struct {
    int         e;
    logic [3:0] v;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en9   = 1'b1;
  logic       en0   = 1'b1;
  logic [3:0] ain9  = 4'h0;
  logic [3:0] ain0  = 4'h0;
  logic [3:0] dout9;
  logic [3:0] dout0;

  int         edge_n  = 0;
  int         n_total = 0;
  int         n_pass  = 0;
  exp_t       q9[$];
  exp_t       q0[$];
  logic [3:0] last9 = 4'h0;
  logic [3:0] last0 = 4'h0;
  logic [15:0] mem9 [int];
  logic [15:0] mem0 [int];
  int         wr9[$];
  int         wr0[$];

  serial_ram_model #(.RAM_ADDR_BITS(AW), .DELAY(DLY9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .enable(en9), .addr_in(ain9), .data_out(dout9));

  serial_ram_model #(.RAM_ADDR_BITS(AW), .DELAY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .addr_in(ain0), .data_out(dout0));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void push(bit sel, logic [3:0] v);
    exp_t x;
    x.e = edge_n + 1;
    x.v = v;
    if (sel) begin
      q0.push_back(x);
      last0 = v;
    end else begin
      q9.push_back(x);
      last9 = v;
    end
  endfunction

  // One clock edge; the unselected instance sits idle and its output settles to 0.
  task automatic tick(input bit sel, input logic [3:0] nib, input bit en, input logic [3:0] exp);
    @(negedge clk);
    rst_n = 1'b1;
    if (sel) begin
      ain0 = nib; en0 = en; ain9 = 4'h0; en9 = 1'b1; last9 = 4'h0;
    end else begin
      ain9 = nib; en9 = en; ain0 = 4'h0; en0 = 1'b1; last0 = 4'h0;
    end
    push(sel, exp);
  endtask

  task automatic rst_tick(input logic [3:0] nib);
    @(negedge clk);
    rst_n = 1'b0;
    ain9 = nib; ain0 = nib; en9 = 1'b1; en0 = 1'b1;
    push(1'b0, 4'h0);
    push(1'b1, 4'h0);
  endtask

  // Random enable-low cycles hold the output, then one real step.
  task automatic step(input bit sel, input logic [3:0] nib, input logic [3:0] exp, input int pct);
    for (int s = 0; s < 3 && $urandom_range(99) < pct; s++)
      tick(sel, 4'($urandom_range(15)), 1'b0, sel ? last0 : last9);
    tick(sel, nib, 1'b1, exp);
  endtask

  function automatic logic [15:0] ref_word(bit sel, logic [15:0] a);
    if (sel && mem0.exists(int'(a))) return mem0[int'(a)];
    if (!sel && mem9.exists(int'(a))) return mem9[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [3:0] junk(int jmode);
    if (jmode == 1) return 4'h1;
    if (jmode == 2) return 4'($urandom_range(15));
    return 4'h0;
  endfunction

  task automatic do_write(input bit sel, input logic [15:0] a, input logic [15:0] d, input int pct);
    step(sel, 4'h3, 4'h0, pct);
    for (int i = 0; i < NA; i++) step(sel, a[4*i +: 4], 4'h0, pct);
    for (int i = 0; i < 4; i++) step(sel, d[4*i +: 4], 4'h0, pct);
    if (sel) begin
      if (!mem0.exists(int'(a))) wr0.push_back(int'(a));
      mem0[int'(a)] = d;
    end else begin
      if (!mem9.exists(int'(a))) wr9.push_back(int'(a));
      mem9[int'(a)] = d;
    end
  endtask

  task automatic do_read(input bit sel, input logic [15:0] a, input int pct, input int jmode,
                         input int stall_at, input int stall_len);
    logic [15:0] w;
    int dly;
    w   = ref_word(sel, a);
    dly = sel ? 0 : DLY9;
    step(sel, 4'h1, 4'h0, pct);
    for (int i = 0; i < NA; i++) step(sel, a[4*i +: 4], 4'h0, pct);
    for (int d = 0; d < dly; d++) begin
      if (d == stall_at)
        for (int s = 0; s < stall_len; s++) tick(sel, 4'h1, 1'b0, 4'h0);
      step(sel, junk(jmode), 4'h0, pct);
    end
    for (int i = 0; i < 4; i++) step(sel, junk(jmode), w[4*i +: 4], pct);
  endtask

  // Address nibbles of 0x1234 with no start nibble: a wrongly started read would return 0xABCD.
  task automatic decoy(input bit sel);
    tick(sel, 4'h4, 1'b1, 4'h0);
    tick(sel, 4'h3, 1'b1, 4'h0);
    tick(sel, 4'h2, 1'b1, 4'h0);
    tick(sel, 4'h1, 1'b1, 4'h0);
    repeat (16) tick(sel, 4'h0, 1'b1, 4'h0);
  endtask

  function automatic void chk(string nm, int e, logic [3:0] act, logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge %0d: data_out=%h expected %h", nm, e, act, exp);
  endfunction

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      while (q9.size() > 0 && q9[0].e <= edge_n) begin
        x = q9.pop_front();
        chk("dly9", x.e, (x.e == edge_n) ? dout9 : 4'hx, x.v);
      end
      while (q0.size() > 0 && q0[0].e <= edge_n) begin
        x = q0.pop_front();
        chk("dly0", x.e, (x.e == edge_n) ? dout0 : 4'hx, x.v);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] a;
    bit sel;
    repeat (3) rst_tick(4'h1);

    do_write(1'b0, 16'h1234, 16'hABCD, 0);
    do_read(1'b0, 16'h1234, 0, 0, -1, 0);
    tick(1'b0, 4'h0, 1'b1, 4'h0);

    repeat (3) rst_tick(4'h1);
    decoy(1'b0);

    do_read(1'b0, 16'h1234, 0, 0, 3, 5);
    tick(1'b0, 4'h0, 1'b1, 4'h0);

    do_read(1'b0, 16'h1234, 0, 1, -1, 0);
    decoy(1'b0);

    do_write(1'b1, 16'h1234, 16'hABCD, 0);
    do_read(1'b1, 16'h1234, 0, 0, -1, 0);
    tick(1'b1, 4'h0, 1'b1, 4'h0);
    do_read(1'b1, 16'h1234, 0, 1, -1, 0);
    decoy(1'b1);

`ifdef SERIAL_RAM_INIT_EN
    do_read(1'b0, 16'h0000, 0, 0, -1, 0);
    tick(1'b0, 4'h0, 1'b1, 4'h0);
    do_read(1'b0, 16'hFFFF, 0, 0, -1, 0);
    tick(1'b0, 4'h0, 1'b1, 4'h0);
`endif

    do_write(1'b0, 16'h0010, 16'h5A3C, 0);
    tick(1'b0, 4'h3, 1'b1, 4'h0);
    tick(1'b0, 4'h0, 1'b1, 4'h0);
    tick(1'b0, 4'h1, 1'b1, 4'h0);
    tick(1'b0, 4'h0, 1'b1, 4'h0);
    tick(1'b0, 4'h0, 1'b1, 4'h0);
    tick(1'b0, 4'h7, 1'b1, 4'h0);
    tick(1'b0, 4'h7, 1'b1, 4'h0);
    rst_tick(4'h0);
    do_read(1'b0, 16'h0010, 0, 0, -1, 0);
    tick(1'b0, 4'h0, 1'b1, 4'h0);

    for (int n = 0; n < 60; n++) begin
      sel = 1'($urandom_range(1));
      if ($urandom_range(1) == 0) begin
        if ($urandom_range(3) == 0 && (sel ? wr0.size() : wr9.size()) > 0)
          a = sel ? 16'(wr0[$urandom_range(wr0.size() - 1)]) : 16'(wr9[$urandom_range(wr9.size() - 1)]);
        else
          a = 16'($urandom_range(65535));
        do_write(sel, a, 16'($urandom_range(65535)), 20);
      end else begin
        a = sel ? 16'(wr0[$urandom_range(wr0.size() - 1)]) : 16'(wr9[$urandom_range(wr9.size() - 1)]);
        do_read(sel, a, 20, 2, -1, 0);
      end
    end
    repeat (3) tick(1'b0, 4'h0, 1'b1, 4'h0);

    repeat (3) @(negedge clk);
    while (q9.size() > 0) begin
      n_total++;
      $display("FAIL dly9 unchecked expectation for edge %0d", q9[0].e);
      void'(q9.pop_front());
    end
    while (q0.size() > 0) begin
      n_total++;
      $display("FAIL dly0 unchecked expectation for edge %0d", q0[0].e);
      void'(q0.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
